fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the pipelined RISC-V core. It sits between the PC register and instruction memory. It issues one fetch at a time over a request/grant/response handshake and holds the fetched word in a one-entry decode buffer. It decides when the PC advances or is redirected from Execute, and it discards stale responses after a redirect.

---
 rtl/fetch_ctrl.sv | 171 +++++++++++++++++
 tb/tb_fetch_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer between the PC register and
// instruction memory.
//
// It issues one fetch at a time over a req/gnt/rvalid handshake and holds the
// fetched word in a one-entry decode buffer. It also decides when the PC
// advances (PC+4) or is redirected from Execute. After a redirect it discards
// the stale response of any fetch that is still in flight.
//
// Ports
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   PCF            current PC from the PC register
//   PCEnF          one-cycle PC load enable
//   RedirF         with PCEnF: load RedirTargetF, otherwise PC loads PCF+4
//   RedirTargetF   word-aligned redirect address
//   PCSrcE         taken branch/JAL in Execute (target PCTargetE)
//   JALRinstr      JALR in Execute (target ALUResultE with bits [1:0] cleared)
//   StallD         Decode stall; the buffered instruction is not consumed
//   imem_*         fetch request/grant/response channel, one outstanding
//   InstrD         buffered instruction
//   InstrValidD    InstrD is valid
module fetch_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] PCF,
  output logic                  PCEnF,
  output logic                  RedirF,
  output logic [DATA_WIDTH-1:0] RedirTargetF,
  input  logic                  PCSrcE,
  input  logic                  JALRinstr,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  input  logic [DATA_WIDTH-1:0] ALUResultE,
  input  logic                  StallD,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic                  InstrValidD
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~{{(DATA_WIDTH-2){1'b0}}, 2'b11};

  state_t                state_q, state_d;
  logic                  pend_q, pend_d;
  logic [DATA_WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  valid_q, valid_d;

  logic                  redir_s;
  logic [DATA_WIDTH-1:0] redir_tgt_s;
  logic                  buf_free_s;

  // Redirect request and target from Execute; JALR takes priority.
  always_comb begin
    redir_s    = PCSrcE | JALRinstr;
    buf_free_s = ~valid_q | ~StallD;
    if (JALRinstr) begin
      redir_tgt_s = ALUResultE & ALIGN_MASK;
    end else begin
      redir_tgt_s = PCTargetE;
    end
  end

  // Next-state, buffer and PC-control logic.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pend_tgt_d   = pend_tgt_q;
    instr_d      = instr_q;
    // Default buffer behaviour: an entry is consumed when Decode is not stalled.
    valid_d      = valid_q & StallD;
    imem_req     = 1'b0;
    PCEnF        = 1'b0;
    RedirF       = 1'b0;
    RedirTargetF = redir_tgt_s;

    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redir_s) begin
          PCEnF   = 1'b1;
          RedirF  = 1'b1;
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q & StallD;
        end
      end

      REQ: begin
        if (redir_s) begin
          // The request is withdrawn while the PC changes, so no grant is taken
          // against a stale address.
          PCEnF   = 1'b1;
          RedirF  = 1'b1;
          valid_d = 1'b0;
        end else begin
          imem_req = buf_free_s;
          if (buf_free_s && imem_gnt) begin
            state_d = RESP;
          end else begin
            state_d = REQ;
          end
        end
      end

      RESP: begin
        if (imem_rvalid) begin
          state_d = REQ;
          PCEnF   = 1'b1;
          if (redir_s) begin
            // Same-cycle redirect: drop the data and redirect right away; it
            // also supersedes any older pending target.
            RedirF  = 1'b1;
            valid_d = 1'b0;
            pend_d  = 1'b0;
          end else if (pend_q) begin
            RedirF       = 1'b1;
            RedirTargetF = pend_tgt_q;
            pend_d       = 1'b0;
          end else begin
            instr_d = imem_rdata;
            valid_d = 1'b1;
          end
        end else if (redir_s) begin
          // The fetch cannot be cancelled; remember the latest target and apply
          // it when the stale response returns.
          pend_d     = 1'b1;
          pend_tgt_d = redir_tgt_s;
          valid_d    = 1'b0;
        end else begin
          state_d = RESP;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and buffer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_q     <= 1'b0;
      pend_tgt_q <= {DATA_WIDTH{1'b0}};
      instr_q    <= {DATA_WIDTH{1'b0}};
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  assign imem_addr   = PCF;
  assign InstrD      = instr_q;
  assign InstrValidD = valid_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: a directed vector table covering the fetch,
// stall, redirect and reset scenarios; a zero-wait throughput sequence; and a
// randomized run checked against a transaction-level reference model.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] PCF;
  logic        PCEnF, RedirF;
  logic [31:0] RedirTargetF;
  logic        PCSrcE = 1'b0, JALRinstr = 1'b0, StallD = 1'b0;
  logic [31:0] PCTargetE = 32'd0, ALUResultE = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] InstrD;
  logic        InstrValidD;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .PCF(PCF), .PCEnF(PCEnF), .RedirF(RedirF),
    .RedirTargetF(RedirTargetF), .PCSrcE(PCSrcE), .JALRinstr(JALRinstr),
    .PCTargetE(PCTargetE), .ALUResultE(ALUResultE), .StallD(StallD),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .InstrD(InstrD),
    .InstrValidD(InstrValidD)
  );

  // PC register used in the directed phases; the random phase drives PCF from
  // the reference model instead.
  logic        use_model = 1'b0;
  logic [31:0] m_pc = RST_PC;
  logic [31:0] pc_reg;
  always @(posedge clk or posedge reset) begin
    if (reset) pc_reg <= RST_PC;
    else if (PCEnF) pc_reg <= RedirF ? RedirTargetF : pc_reg + 32'd4;
  end
  assign PCF = use_model ? m_pc : pc_reg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit rst, stall, pcsrc, jalr;
    logic [31:0] pt, alu;
    bit gnt, rv;
    logic [31:0] rd;
    bit e_req;
    logic [31:0] e_addr;
    bit e_pcen, e_redir;
    logic [31:0] e_tgt, e_instr;
    bit e_valid;
  } vec_t;

  function automatic vec_t mk(bit rst, bit stall, bit pcsrc, bit jalr,
                              logic [31:0] pt, logic [31:0] alu, bit gnt, bit rv,
                              logic [31:0] rd, bit e_req, logic [31:0] e_addr,
                              bit e_pcen, bit e_redir, logic [31:0] e_tgt,
                              logic [31:0] e_instr, bit e_valid);
    vec_t v;
    v.rst = rst; v.stall = stall; v.pcsrc = pcsrc; v.jalr = jalr;
    v.pt = pt; v.alu = alu; v.gnt = gnt; v.rv = rv; v.rd = rd;
    v.e_req = e_req; v.e_addr = e_addr; v.e_pcen = e_pcen; v.e_redir = e_redir;
    v.e_tgt = e_tgt; v.e_instr = e_instr; v.e_valid = e_valid;
    return v;
  endfunction

  task automatic drive(bit rst, bit stall, bit pcsrc, bit jalr, logic [31:0] pt,
                       logic [31:0] alu, bit gnt, bit rv, logic [31:0] rd);
    reset = rst; StallD = stall; PCSrcE = pcsrc; JALRinstr = jalr;
    PCTargetE = pt; ALUResultE = alu; imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rd;
  endtask

  // Memory contents seen by the random phase: a fixed function of the address.
  function automatic logic [31:0] memf(logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h13579BDF;
  endfunction

  // Reference model: transaction-level view of the fetch unit.
  bit          m_idle, m_busy, m_pend, m_valid;
  logic [31:0] m_ptgt, m_faddr, m_instr;

  task automatic model_reset();
    m_idle = 1'b1; m_busy = 1'b0; m_pend = 1'b0; m_valid = 1'b0;
    m_ptgt = 32'd0; m_faddr = 32'd0; m_instr = 32'd0; m_pc = RST_PC;
  endtask

  task automatic rand_cycle();
    bit r, st, ps, jr, gn, rv, redir, load, flush;
    bit e_req, e_pcen, e_redir;
    bit n_busy, n_pend, n_valid;
    logic [31:0] pt, alu, rd, tgt, e_tgt, n_ptgt, n_faddr, n_instr, n_pc;
    r  = ($urandom_range(0, 59) == 0);
    st = ($urandom_range(0, 2) == 0);
    ps = !r && ($urandom_range(0, 7) == 0);
    jr = !r && ($urandom_range(0, 9) == 0);
    pt = $urandom; alu = $urandom;
    gn = ($urandom_range(0, 1) == 1);
    rv = m_busy ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
    rd = m_busy ? memf(m_faddr) : $urandom;
    if (r) model_reset();
    drive(r, st, ps, jr, pt, alu, gn, rv, rd);

    redir = ps | jr;
    tgt   = jr ? {alu[31:2], 2'b00} : pt;
    e_req = 1'b0; e_pcen = 1'b0; e_redir = 1'b0; e_tgt = tgt;
    n_busy = m_busy; n_pend = m_pend; n_ptgt = m_ptgt; n_faddr = m_faddr;
    n_instr = m_instr; n_pc = m_pc; load = 1'b0; flush = 1'b0;

    if (m_idle) begin
      if (redir) begin e_pcen = 1'b1; e_redir = 1'b1; flush = 1'b1; end
    end else if (!m_busy) begin
      if (redir) begin
        e_pcen = 1'b1; e_redir = 1'b1; flush = 1'b1;
      end else begin
        e_req = !m_valid || !st;
        if (e_req && gn) begin n_busy = 1'b1; n_faddr = m_pc; end
      end
    end else if (rv) begin
      n_busy = 1'b0;
      e_pcen = 1'b1;
      if (redir) begin
        e_redir = 1'b1; flush = 1'b1; n_pend = 1'b0;
      end else if (m_pend) begin
        e_redir = 1'b1; e_tgt = m_ptgt; n_pend = 1'b0;
      end else begin
        load = 1'b1; n_instr = memf(m_faddr);
      end
    end else if (redir) begin
      n_pend = 1'b1; n_ptgt = tgt; flush = 1'b1;
    end
    n_valid = load ? 1'b1 : (flush ? 1'b0 : (m_valid && st));
    if (e_pcen) n_pc = e_redir ? e_tgt : m_pc + 32'd4;

    #1;
    chk("rnd imem_req", {31'd0, imem_req}, {31'd0, e_req});
    chk("rnd imem_addr", imem_addr, m_pc);
    chk("rnd PCEnF", {31'd0, PCEnF}, {31'd0, e_pcen});
    chk("rnd RedirF", {31'd0, RedirF}, {31'd0, e_redir});
    if (e_pcen && e_redir) chk("rnd RedirTargetF", RedirTargetF, e_tgt);
    chk("rnd InstrD", InstrD, m_instr);
    chk("rnd InstrValidD", {31'd0, InstrValidD}, {31'd0, m_valid});
    @(posedge clk);
    if (!r) begin
      m_idle = 1'b0; m_busy = n_busy; m_pend = n_pend; m_ptgt = n_ptgt;
      m_faddr = n_faddr; m_instr = n_instr; m_valid = n_valid; m_pc = n_pc;
    end
    #1;
  endtask

  localparam logic [31:0] B = RST_PC;

  initial begin
    vec_t vecs[$];
    int pcen_cnt;
    bit granted;

    vecs.push_back(mk(1,0,0,0, 32'd0, 32'd0, 0,0, 32'd0,  0, B,         0,0, 32'd0,      32'd0,        0));
    vecs.push_back(mk(0,0,0,0, 32'd0, 32'd0, 0,0, 32'd0,  0, B,         0,0, 32'd0,      32'd0,        0));
    vecs.push_back(mk(0,0,0,0, 32'd0, 32'd0, 1,0, 32'd0,  1, B,         0,0, 32'd0,      32'd0,        0));
    vecs.push_back(mk(0,0,0,0, 32'd0, 32'd0, 0,1, 32'h00000013, 0, B,   1,0, 32'd0,      32'd0,        0));
    vecs.push_back(mk(0,1,0,0, 32'd0, 32'd0, 1,0, 32'd0,  0, B+32'h4,   0,0, 32'd0,      32'h00000013, 1));
    vecs.push_back(mk(0,1,0,0, 32'd0, 32'd0, 1,0, 32'd0,  0, B+32'h4,   0,0, 32'd0,      32'h00000013, 1));
    vecs.push_back(mk(0,0,0,0, 32'd0, 32'd0, 1,0, 32'd0,  1, B+32'h4,   0,0, 32'd0,      32'h00000013, 1));
    vecs.push_back(mk(0,0,1,0, B+32'h100, 32'd0, 0,0, 32'd0, 0, B+32'h4, 0,0, 32'd0,     32'h00000013, 0));
    vecs.push_back(mk(0,0,0,0, 32'd0, 32'd0, 0,1, 32'hDEADBEEF, 0, B+32'h4, 1,1, B+32'h100, 32'h00000013, 0));
    vecs.push_back(mk(0,0,0,0, 32'd0, 32'd0, 1,0, 32'd0,  1, B+32'h100, 0,0, 32'd0,      32'h00000013, 0));
    vecs.push_back(mk(0,0,0,0, 32'd0, 32'd0, 0,1, 32'h00100093, 0, B+32'h100, 1,0, 32'd0, 32'h00000013, 0));
    vecs.push_back(mk(0,0,0,1, 32'd0, B+32'h203, 0,0, 32'd0, 0, B+32'h104, 1,1, B+32'h200, 32'h00100093, 1));
    vecs.push_back(mk(0,0,0,0, 32'd0, 32'd0, 1,0, 32'd0,  1, B+32'h200, 0,0, 32'd0,      32'h00100093, 0));
    vecs.push_back(mk(0,0,1,0, B+32'h300, 32'd0, 0,0, 32'd0, 0, B+32'h200, 0,0, 32'd0,   32'h00100093, 0));
    vecs.push_back(mk(0,0,1,0, B+32'h400, 32'd0, 0,0, 32'd0, 0, B+32'h200, 0,0, 32'd0,   32'h00100093, 0));
    vecs.push_back(mk(0,0,0,0, 32'd0, 32'd0, 0,1, 32'h11111111, 0, B+32'h200, 1,1, B+32'h400, 32'h00100093, 0));
    vecs.push_back(mk(0,0,0,0, 32'd0, 32'd0, 1,0, 32'd0,  1, B+32'h400, 0,0, 32'd0,      32'h00100093, 0));
    vecs.push_back(mk(0,0,1,0, B+32'h500, 32'd0, 0,1, 32'h22222222, 0, B+32'h400, 1,1, B+32'h500, 32'h00100093, 0));
    vecs.push_back(mk(0,0,0,0, 32'd0, 32'd0, 1,0, 32'd0,  1, B+32'h500, 0,0, 32'd0,      32'h00100093, 0));
    vecs.push_back(mk(1,0,0,0, 32'd0, 32'd0, 0,0, 32'd0,  0, B,         0,0, 32'd0,      32'd0,        0));
    vecs.push_back(mk(0,0,0,0, 32'd0, 32'd0, 0,1, 32'h33333333, 0, B,   0,0, 32'd0,      32'd0,        0));
    vecs.push_back(mk(0,0,0,0, 32'd0, 32'd0, 1,0, 32'd0,  1, B,         0,0, 32'd0,      32'd0,        0));
    vecs.push_back(mk(0,0,0,0, 32'd0, 32'd0, 0,1, 32'h44444444, 0, B,   1,0, 32'd0,      32'd0,        0));
    vecs.push_back(mk(0,1,1,0, B+32'h600, 32'd0, 1,0, 32'd0, 0, B+32'h4, 1,1, B+32'h600, 32'h44444444, 1));
    vecs.push_back(mk(0,1,0,0, 32'd0, 32'd0, 0,0, 32'd0,  1, B+32'h600, 0,0, 32'd0,      32'h44444444, 0));
    vecs.push_back(mk(0,1,0,0, 32'd0, 32'd0, 1,0, 32'd0,  1, B+32'h600, 0,0, 32'd0,      32'h44444444, 0));
    vecs.push_back(mk(0,0,0,0, 32'd0, 32'd0, 1,0, 32'd0,  0, B+32'h600, 0,0, 32'd0,      32'h44444444, 0));
    vecs.push_back(mk(0,0,0,0, 32'd0, 32'd0, 0,1, 32'h55555555, 0, B+32'h600, 1,0, 32'd0, 32'h44444444, 0));
    vecs.push_back(mk(0,1,0,0, 32'd0, 32'd0, 1,0, 32'd0,  0, B+32'h604, 0,0, 32'd0,      32'h55555555, 1));
    vecs.push_back(mk(0,0,0,0, 32'd0, 32'd0, 0,0, 32'd0,  1, B+32'h604, 0,0, 32'd0,      32'h55555555, 1));

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      drive(v.rst, v.stall, v.pcsrc, v.jalr, v.pt, v.alu, v.gnt, v.rv, v.rd);
      #1;
      chk($sformatf("vec%0d imem_req", i), {31'd0, imem_req}, {31'd0, v.e_req});
      chk($sformatf("vec%0d imem_addr", i), imem_addr, v.e_addr);
      chk($sformatf("vec%0d PCEnF", i), {31'd0, PCEnF}, {31'd0, v.e_pcen});
      chk($sformatf("vec%0d RedirF", i), {31'd0, RedirF}, {31'd0, v.e_redir});
      if (v.e_pcen && v.e_redir) chk($sformatf("vec%0d RedirTargetF", i), RedirTargetF, v.e_tgt);
      chk($sformatf("vec%0d InstrD", i), InstrD, v.e_instr);
      chk($sformatf("vec%0d InstrValidD", i), {31'd0, InstrValidD}, {31'd0, v.e_valid});
      @(posedge clk); #1;
    end

    // Zero-wait memory: one instruction every two cycles.
    drive(1, 0, 0, 0, 32'd0, 32'd0, 1, 0, 32'd0);
    @(posedge clk); #1;
    pcen_cnt = 0;
    granted  = 1'b0;
    for (int c = 0; c < 9; c++) begin
      drive(0, 0, 0, 0, 32'd0, 32'd0, 1, granted, 32'h00000013 + c);
      #1;
      if (PCEnF) pcen_cnt++;
      granted = imem_req && imem_gnt;
      @(posedge clk); #1;
    end
    chk("zero-wait PCEnF count", pcen_cnt, 32'd4);
    chk("zero-wait PC", pc_reg, RST_PC + 32'd16);
    chk("zero-wait InstrValidD", {31'd0, InstrValidD}, 32'd1);

    // Randomized run against the reference model.
    drive(1, 0, 0, 0, 32'd0, 32'd0, 0, 0, 32'd0);
    model_reset();
    use_model = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 3000; n++) rand_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
